// File: rtl/victim_cache_pkg.sv
// Shared types and helpers for the victim cache family: line geometry, entry record, byte merge.
// Line width is fixed here; depth and query-port count are parameters of the top.
package victim_cache_pkg;

    localparam int PHYS_WIDTH = 32;
    typedef logic [PHYS_WIDTH-1:0] phys_t;

    localparam int LINE_WIDTH = 256;

    function automatic int label_width(input int line_width);
        return $bits(phys_t) - $clog2(line_width / 8);
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int LABEL_WIDTH = label_width(LINE_WIDTH);
    localparam int BE_WIDTH    = LINE_WIDTH / 8;

    typedef logic [LABEL_WIDTH-1:0] label_t;
    typedef logic [LINE_WIDTH-1:0]  data_t;
    typedef logic [BE_WIDTH-1:0]    be_t;

    typedef struct packed {
        label_t label;
        data_t  data;
    } line_t;

    typedef struct packed {
        logic   valid;
        logic   dirty;
        label_t label;
        data_t  data;
    } vc_entry_t;

    // Replace the bytes of old_data selected by be with the matching bytes of new_data.
    function automatic data_t byte_merge(input data_t old_data, input data_t new_data, input be_t be);
        data_t merged;
        merged = old_data;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/victim_cache_match.sv
// Label CAM: compares one label against every entry and returns hit plus the encoded index.
// Labels are unique among valid entries, so OR-folding the one-hot vector yields the index.
module victim_cache_match
    import victim_cache_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  label_t               label,
    input  logic   [DEPTH-1:0]   valid,
    input  label_t [DEPTH-1:0]   labels,
    output logic                 hit,
    output logic   [AW-1:0]      idx
);

    logic [DEPTH-1:0] onehot;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign onehot[gi] = valid[gi] && (labels[gi] == label);
        end
    endgenerate

    assign hit = |onehot;

    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (onehot[i]) begin
                idx = idx | AW'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache_mq.sv
// Multi-port victim cache: FIFO of evicted lines, searchable by label, with push-merge and byte write-merge.
// Build option: define VICTIM_CACHE_FWD_EN to forward same-cycle push/write data to the query channels.
module victim_cache_mq
    import victim_cache_pkg::*;
#(
    parameter int LINE_DEPTH  = 8,
    parameter int QUERY_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  line_t                        pline,
    input  logic                         pdirty,
    output logic                         pushed,
    input  logic                         pop,
    output line_t                        rline,
    output logic                         rdirty,
    output logic                         full,
    output logic                         empty,
    input  label_t [QUERY_PORTS-1:0]     query_label,
    output logic   [QUERY_PORTS-1:0]     query_found,
    output data_t  [QUERY_PORTS-1:0]     query_rdata,
    input  logic                         write,
    input  label_t                       wlabel,
    input  data_t                        wdata,
    input  be_t                          wbe,
    output logic                         written
);

    localparam int AW = addr_width(LINE_DEPTH);
    localparam int CW = AW + 1;

    vc_entry_t         entries_reg [LINE_DEPTH];
    logic [AW-1:0]     head_reg, head_next;
    logic [AW-1:0]     tail_reg, tail_next;
    logic [CW-1:0]     count_reg, count_next;

    logic   [LINE_DEPTH-1:0] entry_valid;
    label_t [LINE_DEPTH-1:0] entry_label;

    generate
        for (genvar gi = 0; gi < LINE_DEPTH; gi++) begin : g_flat
            assign entry_valid[gi] = entries_reg[gi].valid;
            assign entry_label[gi] = entries_reg[gi].label;
        end
    endgenerate

    logic          p_hit, w_hit;
    logic [AW-1:0] p_idx, w_idx;

    victim_cache_match #(.DEPTH(LINE_DEPTH), .AW(AW)) u_push_match (
        .label  (pline.label),
        .valid  (entry_valid),
        .labels (entry_label),
        .hit    (p_hit),
        .idx    (p_idx)
    );

    victim_cache_match #(.DEPTH(LINE_DEPTH), .AW(AW)) u_write_match (
        .label  (wlabel),
        .valid  (entry_valid),
        .labels (entry_label),
        .hit    (w_hit),
        .idx    (w_idx)
    );

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(LINE_DEPTH));

    logic  pop_eff, merge_ok, new_ok, write_ok;
    data_t merge_data;

    // A pop retires the head this edge, so merges or writes aimed at it are dropped.
    assign pop_eff    = pop && !empty;
    assign merge_ok   = push && p_hit && !(pop_eff && (p_idx == head_reg));
    assign new_ok     = push && !p_hit && (!full || pop_eff);
    assign write_ok   = write && w_hit && !(pop_eff && (w_idx == head_reg))
                        && !(merge_ok && (p_idx == w_idx));
    assign merge_data = byte_merge(entries_reg[w_idx].data, wdata, wbe);

    assign pushed  = rst && (merge_ok || new_ok);
    assign written = rst && write_ok;

    assign rline  = empty ? '0 : {entries_reg[head_reg].label, entries_reg[head_reg].data};
    assign rdirty = !empty && entries_reg[head_reg].dirty;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop_eff) begin
            head_next = head_reg + 1'b1;
        end
        if (new_ok) begin
            tail_next = tail_reg + 1'b1;
        end
        case ({new_ok, pop_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < LINE_DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            if (pop_eff) begin
                entries_reg[head_reg].valid <= 1'b0;
            end
            // When full with a pop, tail equals head and this later write recycles the slot.
            if (new_ok) begin
                entries_reg[tail_reg] <= '{valid: 1'b1, dirty: pdirty, label: pline.label, data: pline.data};
            end
            if (merge_ok) begin
                entries_reg[p_idx].data  <= pline.data;
                entries_reg[p_idx].dirty <= entries_reg[p_idx].dirty | pdirty;
            end
            if (write_ok) begin
                entries_reg[w_idx].data  <= merge_data;
                entries_reg[w_idx].dirty <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < QUERY_PORTS; gi++) begin : g_query
            logic          q_hit;
            logic [AW-1:0] q_idx;
            logic          q_found;
            data_t         q_data;

            victim_cache_match #(.DEPTH(LINE_DEPTH), .AW(AW)) u_match (
                .label  (query_label[gi]),
                .valid  (entry_valid),
                .labels (entry_label),
                .hit    (q_hit),
                .idx    (q_idx)
            );

`ifdef VICTIM_CACHE_FWD_EN
            always_comb begin
                q_found = 1'b0;
                q_data  = '0;
                if (rst) begin
                    if (push && (pline.label == query_label[gi])) begin
                        q_found = 1'b1;
                        q_data  = pline.data;
                    end else if (write_ok && (wlabel == query_label[gi])) begin
                        q_found = 1'b1;
                        q_data  = merge_data;
                    end else if (q_hit) begin
                        q_found = 1'b1;
                        q_data  = entries_reg[q_idx].data;
                    end
                end
            end
`else
            always_comb begin
                q_found = 1'b0;
                q_data  = '0;
                if (rst && q_hit) begin
                    q_found = 1'b1;
                    q_data  = entries_reg[q_idx].data;
                end
            end
`endif
            assign query_found[gi] = q_found;
            assign query_rdata[gi] = q_data;
        end
    endgenerate

endmodule
